// File: rtl/pheap_pkg.sv
// Shared definitions for the pipelined heap (pheap): opcodes, EXEC outcome
// classes and the unsigned key-ordering helper used by every level.
package pheap_pkg;

  // Operations travelling down the level chain.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    LEQ  = 2'd1,
    DEQ  = 2'd2
  } opcode_t;

  // Outcome of the single EXEC cycle of a level stage.
  typedef enum logic [1:0] {
    DONE_NOP   = 2'd0,
    DONE_WRITE = 2'd1,
    DONE_PUSH  = 2'd2,
    DONE_ERR   = 2'd3
  } done_t;

  // Widest key the ordering helper handles; narrower keys are zero-extended.
  localparam int KEY_MAX_W = 64;

  // True when key a strictly beats key b: smaller for a min-heap, larger for a
  // max-heap. Equal keys never win, which is what keeps residents on ties.
  function automatic logic better(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b,
                                  input logic                 max_mode);
    return max_mode ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/pheap_node_cmp.sv
// Combinational winner/loser select between a resident (a) and a challenger
// (b). The challenger only wins on a strictly better key, so ties favour a.
// Used for resident-vs-incoming on LEQ and left-vs-right child on DEQ.
module pheap_node_cmp
  import pheap_pkg::*;
#(
  parameter int KW       = 32,
  parameter int DW       = 32,
  parameter int MAX_MODE = 0
) (
  input  logic [KW-1:0] a_key,
  input  logic [DW-1:0] a_data,
  input  logic [KW-1:0] b_key,
  input  logic [DW-1:0] b_data,
  output logic          b_wins,
  output logic [KW-1:0] win_key,
  output logic [DW-1:0] win_data,
  output logic [KW-1:0] lose_key,
  output logic [DW-1:0] lose_data
);

  // Order the pair; a keeps the win unless b is strictly better.
  always_comb begin
    b_wins = better(KEY_MAX_W'(b_key), KEY_MAX_W'(a_key), (MAX_MODE != 0));
    if (b_wins) begin
      win_key   = b_key;
      win_data  = b_data;
      lose_key  = a_key;
      lose_data = a_data;
    end else begin
      win_key   = a_key;
      win_data  = a_data;
      lose_key  = b_key;
      lose_data = b_data;
    end
  end

endmodule

// File: rtl/pheap_level_stage.sv
// One level of the pipelined heap. Holds 2**LEVEL nodes, executes FREE/LEQ/DEQ
// ops from the parent in a two-state IDLE/EXEC loop, forwards displaced or
// refill ops to the child level through a registered dn_* port, and serves
// combinational child reads to the parent.
// Optional feature: define PHEAP_OCC_EN to add the registered occ output
// (count of active nodes in this level).
module pheap_level_stage
  import pheap_pkg::*;
#(
  parameter  int LEVELS   = 4,
  parameter  int LEVEL    = 0,
  parameter  int KW       = 32,
  parameter  int DW       = 32,
  parameter  int MAX_MODE = 0,
  localparam int IW       = (LEVEL > 0) ? LEVEL : 1,
  localparam int CW       = LEVELS - LEVEL,
  localparam int EW       = 1 + KW + DW + CW,
  localparam int CEW      = EW - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  output logic            up_ready,
  input  opcode_t         up_op,
  input  logic [IW-1:0]   up_idx,
  input  logic [KW-1:0]   up_key,
  input  logic [DW-1:0]   up_data,
  input  logic [IW-1:0]   rd_pidx,
  output logic [EW-1:0]   rd_l,
  output logic [EW-1:0]   rd_r,
  output logic            dn_valid,
  input  logic            dn_ready,
  output opcode_t         dn_op,
  output logic [LEVEL:0]  dn_idx,
  output logic [KW-1:0]   dn_key,
  output logic [DW-1:0]   dn_data,
  output logic [IW-1:0]   dn_rd_pidx,
  input  logic [CEW-1:0]  dn_rd_l,
  input  logic [CEW-1:0]  dn_rd_r,
  output logic            err
`ifdef PHEAP_OCC_EN
  ,
  output logic [LEVEL:0]  occ
`endif
);

  localparam int             NN       = 1 << LEVEL;
  localparam int             DNW      = LEVEL + 1;
  localparam bit             IS_LEAF  = (LEVEL == LEVELS - 1);
  localparam logic [CW-1:0]  CAP_FULL = {CW{1'b1}};
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_EXEC  = 1'b1;

  // Node storage: active/cap are control state, key/data are plain datapath.
  logic          active_q [NN];
  logic [CW-1:0] cap_q    [NN];
  logic [KW-1:0] key_q    [NN];
  logic [DW-1:0] data_q   [NN];

  logic [0:0]    state;
  logic          rdy_en_q;
  logic          dn_vld_q;

  // Op latched on acceptance, consumed by EXEC.
  opcode_t       op_p0;
  logic [IW-1:0] idx_p0;
  logic [KW-1:0] key_p0;
  logic [DW-1:0] data_p0;
  logic [IW-1:0] nidx;

  // Resident node under execution.
  logic          cur_act;
  logic [CW-1:0] cur_cap;
  logic [KW-1:0] cur_key;
  logic [DW-1:0] cur_data;

  // Child entries read through dn_rd_pidx.
  logic          cl_act, cr_act, cl_room;
  logic [KW-1:0] cl_key, cr_key;
  logic [DW-1:0] cl_data, cr_data;

  // Comparator results.
  logic          leq_in_wins;
  logic [KW-1:0] leq_win_key, leq_lose_key;
  logic [DW-1:0] leq_win_data, leq_lose_data;
  logic          cr_better;
  logic [KW-1:0] ch_win_key, ch_lose_key_unused;
  logic [DW-1:0] ch_win_data, ch_lose_data_unused;
  logic          pick_r;
  logic [KW-1:0] pick_key;
  logic [DW-1:0] pick_data;

  // EXEC next-state values.
  done_t          done;
  logic           wr_act;
  logic [CW-1:0]  wr_cap;
  logic [KW-1:0]  wr_key;
  logic [DW-1:0]  wr_data;
  opcode_t        push_op;
  logic           push_sel;
  logic [KW-1:0]  push_key;
  logic [DW-1:0]  push_data;
  logic [DNW-1:0] push_idx;

  assign nidx       = (LEVEL == 0) ? '0 : idx_p0;
  assign cur_act    = active_q[nidx];
  assign cur_cap    = cap_q[nidx];
  assign cur_key    = key_q[nidx];
  assign cur_data   = data_q[nidx];

  assign up_ready   = rst_n && rdy_en_q && (state == ST_IDLE) && !dn_vld_q;
  assign dn_valid   = dn_vld_q;
  assign dn_rd_pidx = nidx;

  // Child entry fields: {active, key, data, cap}, cap one bit narrower here.
  assign cl_act  = dn_rd_l[CEW-1];
  assign cl_key  = dn_rd_l[CEW-2 -: KW];
  assign cl_data = dn_rd_l[CEW-2-KW -: DW];
  assign cr_act  = dn_rd_r[CEW-1];
  assign cr_key  = dn_rd_r[CEW-2 -: KW];
  assign cr_data = dn_rd_r[CEW-2-KW -: DW];

  generate
    if (IS_LEAF) begin : g_leaf
      assign cl_room = 1'b0;
    end else begin : g_inner
      logic rdr_cap_unused;
      assign cl_room        = |dn_rd_l[CW-2:0];
      assign rdr_cap_unused = ^dn_rd_r[CW-2:0];
    end
  endgenerate

  // Parent-facing child reads: children 2p and 2p+1, or the root at level 0.
  generate
    if (LEVEL == 0) begin : g_root_rd
      logic rd_in_unused;
      assign rd_in_unused = ^{rd_pidx, up_idx};
      assign rd_l = {active_q[0], key_q[0], data_q[0], cap_q[0]};
      assign rd_r = '0;
    end else begin : g_rd
      logic [IW-1:0] li, ri;
      assign li   = rd_pidx << 1;
      assign ri   = li | IW'(1);
      assign rd_l = {active_q[li], key_q[li], data_q[li], cap_q[li]};
      assign rd_r = {active_q[ri], key_q[ri], data_q[ri], cap_q[ri]};
    end
  endgenerate

  pheap_node_cmp #(.KW(KW), .DW(DW), .MAX_MODE(MAX_MODE)) u_leq_cmp (
    .a_key     (cur_key),
    .a_data    (cur_data),
    .b_key     (key_p0),
    .b_data    (data_p0),
    .b_wins    (leq_in_wins),
    .win_key   (leq_win_key),
    .win_data  (leq_win_data),
    .lose_key  (leq_lose_key),
    .lose_data (leq_lose_data)
  );

  pheap_node_cmp #(.KW(KW), .DW(DW), .MAX_MODE(MAX_MODE)) u_child_cmp (
    .a_key     (cl_key),
    .a_data    (cl_data),
    .b_key     (cr_key),
    .b_data    (cr_data),
    .b_wins    (cr_better),
    .win_key   (ch_win_key),
    .win_data  (ch_win_data),
    .lose_key  (ch_lose_key_unused),
    .lose_data (ch_lose_data_unused)
  );

  // A lone active child is taken as-is; with two, the comparator decides.
  assign pick_r    = (cl_act && cr_act) ? cr_better : cr_act;
  assign pick_key  = (cl_act && cr_act) ? ch_win_key  : (cr_act ? cr_key  : cl_key);
  assign pick_data = (cl_act && cr_act) ? ch_win_data : (cr_act ? cr_data : cl_data);
  assign push_idx  = DNW'({nidx, push_sel});

  // ---- p0 -> EXEC: decide the node update and any op for the child level ----
  // Decode the latched op against the resident node and the child reads.
  always_comb begin
    done      = DONE_NOP;
    wr_act    = cur_act;
    wr_cap    = cur_cap;
    wr_key    = cur_key;
    wr_data   = cur_data;
    push_op   = FREE;
    push_sel  = 1'b0;
    push_key  = '0;
    push_data = '0;
    case (op_p0)
      LEQ: begin
        if (cur_cap == '0) begin
          done = DONE_ERR;
        end else if (!cur_act) begin
          done    = DONE_WRITE;
          wr_act  = 1'b1;
          wr_key  = key_p0;
          wr_data = data_p0;
          wr_cap  = cur_cap - CW'(1);
        end else begin
          done      = DONE_PUSH;
          wr_key    = leq_win_key;
          wr_data   = leq_win_data;
          wr_cap    = cur_cap - CW'(1);
          push_op   = LEQ;
          push_sel  = !cl_room;
          push_key  = leq_lose_key;
          push_data = leq_lose_data;
        end
      end
      DEQ: begin
        if (!cur_act) begin
          done = DONE_ERR;
        end else if (IS_LEAF || (!cl_act && !cr_act)) begin
          done   = DONE_WRITE;
          wr_act = 1'b0;
          wr_cap = cur_cap + CW'(1);
        end else begin
          done     = DONE_PUSH;
          wr_key   = pick_key;
          wr_data  = pick_data;
          wr_cap   = cur_cap + CW'(1);
          push_op  = DEQ;
          push_sel = pick_r;
        end
      end
      default: ;
    endcase
  end

  // Control state: FSM, ready gate, dn valid, err pulse, node active/cap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rdy_en_q <= 1'b0;
      dn_vld_q <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        active_q[i] <= 1'b0;
        cap_q[i]    <= CAP_FULL;
      end
    end else begin
      rdy_en_q <= 1'b1;
      err      <= 1'b0;
      if (dn_vld_q && dn_ready) dn_vld_q <= 1'b0;
      case (state)
        ST_IDLE: if (up_valid && up_ready) state <= ST_EXEC;
        ST_EXEC: begin
          state <= ST_IDLE;
          if (done == DONE_ERR) err <= 1'b1;
          if (done == DONE_WRITE || done == DONE_PUSH) begin
            active_q[nidx] <= wr_act;
            cap_q[nidx]    <= wr_cap;
          end
          if (done == DONE_PUSH && !IS_LEAF) dn_vld_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- IDLE -> p0: latch the accepted op; EXEC -> dn: load node and dn data ----
  // Datapath registers; writes are gated by rst_n so a reset mid-op leaves no trace.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && up_valid && up_ready) begin
      op_p0   <= up_op;
      idx_p0  <= up_idx;
      key_p0  <= up_key;
      data_p0 <= up_data;
    end
    if (rst_n && state == ST_EXEC && (done == DONE_WRITE || done == DONE_PUSH)) begin
      key_q[nidx]  <= wr_key;
      data_q[nidx] <= wr_data;
    end
    if (rst_n && state == ST_EXEC && done == DONE_PUSH) begin
      dn_op   <= push_op;
      dn_idx  <= push_idx;
      dn_key  <= push_key;
      dn_data <= push_data;
    end
  end

`ifdef PHEAP_OCC_EN
  logic occ_inc, occ_dec;
  assign occ_inc = (state == ST_EXEC) && (op_p0 == LEQ) && (done == DONE_WRITE);
  assign occ_dec = (state == ST_EXEC) && (op_p0 == DEQ) && (done == DONE_WRITE);

  // Occupancy: a node fills on LEQ into an empty slot and empties on a final DEQ.
  always_ff @(posedge clk) begin
    if (!rst_n)       occ <= '0;
    else if (occ_inc) occ <= occ + DNW'(1);
    else if (occ_dec) occ <= occ - DNW'(1);
  end
`endif

endmodule

// File: tb/tb_pheap_level_stage.sv
// Self-checking bench for pheap_level_stage at LEVELS=3, LEVEL=1, KW=DW=8,
// min-heap. The bench plays both parent (drives up_*) and the leaf child level
// (answers dn_rd_* and absorbs dn ops). Expected dn ops go into a scoreboard
// queue when an op is issued and are popped when the DUT hands them down.
module tb_pheap_level_stage;
  import pheap_pkg::*;

  localparam int LEVELS = 3;
  localparam int LEVEL  = 1;
  localparam int KW     = 8;
  localparam int DW     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  opcode_t     up_op = FREE;
  logic [0:0]  up_idx = '0;
  logic [7:0]  up_key = '0;
  logic [7:0]  up_data = '0;
  logic [0:0]  rd_pidx = '0;
  logic [18:0] rd_l, rd_r;
  logic        dn_valid;
  logic        dn_ready = 1'b1;
  opcode_t     dn_op;
  logic [1:0]  dn_idx;
  logic [7:0]  dn_key, dn_data;
  logic [0:0]  dn_rd_pidx;
  logic [17:0] dn_rd_l, dn_rd_r;
  logic        err;
`ifdef PHEAP_OCC_EN
  logic [1:0]  occ;
`endif

  always #5 clk = ~clk;

  pheap_level_stage #(.LEVELS(LEVELS), .LEVEL(LEVEL), .KW(KW), .DW(DW), .MAX_MODE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_op      (up_op),
    .up_idx     (up_idx),
    .up_key     (up_key),
    .up_data    (up_data),
    .rd_pidx    (rd_pidx),
    .rd_l       (rd_l),
    .rd_r       (rd_r),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_op      (dn_op),
    .dn_idx     (dn_idx),
    .dn_key     (dn_key),
    .dn_data    (dn_data),
    .dn_rd_pidx (dn_rd_pidx),
    .dn_rd_l    (dn_rd_l),
    .dn_rd_r    (dn_rd_r),
    .err        (err)
`ifdef PHEAP_OCC_EN
    ,
    .occ        (occ)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Leaf child model: four nodes, cap is one bit.
  logic       ch_act  [4];
  logic [7:0] ch_key  [4];
  logic [7:0] ch_data [4];
  logic       ch_cap  [4];
  logic [1:0] cb_l, cb_r;
  assign cb_l    = {dn_rd_pidx, 1'b0};
  assign cb_r    = {dn_rd_pidx, 1'b1};
  assign dn_rd_l = {ch_act[cb_l], ch_key[cb_l], ch_data[cb_l], ch_cap[cb_l]};
  assign dn_rd_r = {ch_act[cb_r], ch_key[cb_r], ch_data[cb_r], ch_cap[cb_r]};

  // Reference model of this level's two nodes.
  logic       n_act  [2];
  logic [7:0] n_key  [2];
  logic [7:0] n_data [2];
  logic [1:0] n_cap  [2];

  logic [63:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [1:0] op, input logic [1:0] idx,
                                       input logic [7:0] k, input logic [7:0] d);
    logic [7:0] kk, dd;
    kk = (op == DEQ) ? 8'h00 : k;
    dd = (op == DEQ) ? 8'h00 : d;
    return {44'b0, op, idx, kk, dd};
  endfunction

  // Scoreboard side: every dn handshake is compared, then applied to the child.
  task automatic monitor();
    logic [63:0] obs, exp;
    if (rst_n && dn_valid && dn_ready) begin
      obs = pack(dn_op, dn_idx, dn_key, dn_data);
      if (sb_q.size() == 0) begin
        chk("dn_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp = sb_q.pop_front();
        chk("dn_txn", obs, exp);
      end
      if (dn_op == LEQ) begin
        ch_act[dn_idx]  = 1'b1;
        ch_key[dn_idx]  = dn_key;
        ch_data[dn_idx] = dn_data;
        ch_cap[dn_idx]  = 1'b0;
      end else if (dn_op == DEQ) begin
        ch_act[dn_idx] = 1'b0;
        ch_cap[dn_idx] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic node_chk(input string tag);
    logic [18:0] e;
    for (int i = 0; i < 2; i++) begin
      e = (i == 0) ? rd_l : rd_r;
      chk($sformatf("%s_n%0d_act", tag, i), 64'(e[18]), 64'(n_act[i]));
      chk($sformatf("%s_n%0d_cap", tag, i), 64'(e[1:0]), 64'(n_cap[i]));
      if (n_act[i]) begin
        chk($sformatf("%s_n%0d_key", tag, i), 64'(e[17:10]), 64'(n_key[i]));
        chk($sformatf("%s_n%0d_data", tag, i), 64'(e[9:2]), 64'(n_data[i]));
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      n_act[i] = 1'b0; n_key[i] = '0; n_data[i] = '0; n_cap[i] = 2'd3;
    end
    for (int i = 0; i < 4; i++) begin
      ch_act[i] = 1'b0; ch_key[i] = '0; ch_data[i] = '0; ch_cap[i] = 1'b1;
    end
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_valid = 1'b0;
    tick();
    tick();
    chk("rst_up_ready", 64'(up_ready), 64'd0);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    model_clear();
    rst_n = 1'b1;
    chk("rel_up_ready_0", 64'(up_ready), 64'd0);
    tick();
    chk("rel_up_ready_1", 64'(up_ready), 64'd1);
    chk("rel_dn_valid", 64'(dn_valid), 64'd0);
    node_chk("rst");
  endtask

  // Issue one op: model it, queue any expected dn op, drive it, check EXEC result.
  task automatic send(input opcode_t op, input logic idx, input logic [7:0] key,
                      input logic [7:0] data);
    int   n;
    logic exp_err;
    logic sel, pr;
    logic [1:0] l, r, p;
    n = 0;
    while (!up_ready && n < 20) begin
      tick();
      n++;
    end
    if (!up_ready) begin
      chk("up_ready_timeout", 64'(up_ready), 64'd1);
      return;
    end
    exp_err = 1'b0;
    l = {idx, 1'b0};
    r = {idx, 1'b1};
    if (op == LEQ) begin
      if (n_cap[idx] == 2'd0) begin
        exp_err = 1'b1;
      end else if (!n_act[idx]) begin
        n_act[idx] = 1'b1; n_key[idx] = key; n_data[idx] = data;
        n_cap[idx] = n_cap[idx] - 2'd1;
      end else begin
        sel = !ch_cap[l];
        if (key < n_key[idx]) begin
          sb_q.push_back(pack(LEQ, {idx, sel}, n_key[idx], n_data[idx]));
          n_key[idx] = key; n_data[idx] = data;
        end else begin
          sb_q.push_back(pack(LEQ, {idx, sel}, key, data));
        end
        n_cap[idx] = n_cap[idx] - 2'd1;
      end
    end else if (op == DEQ) begin
      if (!n_act[idx]) begin
        exp_err = 1'b1;
      end else if (!ch_act[l] && !ch_act[r]) begin
        n_act[idx] = 1'b0;
        n_cap[idx] = n_cap[idx] + 2'd1;
      end else begin
        pr = ch_act[r] && (!ch_act[l] || (ch_key[r] < ch_key[l]));
        p  = pr ? r : l;
        n_key[idx] = ch_key[p]; n_data[idx] = ch_data[p];
        sb_q.push_back(pack(DEQ, p, 8'h00, 8'h00));
        n_cap[idx] = n_cap[idx] + 2'd1;
      end
    end
    up_valid = 1'b1; up_op = op; up_idx = idx; up_key = key; up_data = data;
    tick();
    up_valid = 1'b0;
    tick();
    chk("err", 64'(err), 64'(exp_err));
    node_chk("exec");
    if (exp_err) begin
      tick();
      chk("err_pulse_end", 64'(err), 64'd0);
    end
  endtask

  initial begin
    model_clear();
    do_reset();

    // Displacement: smaller key takes the node, old resident goes to child 0.
    send(LEQ, 1'b0, 8'd20, 8'h20);
    send(LEQ, 1'b0, 8'd10, 8'h10);
    chk("leq_key", 64'(rd_l[17:10]), 64'd10);
    chk("leq_cap", 64'(rd_l[1:0]), 64'd1);

    // Tie: resident stays, incoming goes to child 1 since child 0 is full.
    send(LEQ, 1'b0, 8'd10, 8'hB2);
    chk("tie_data", 64'(rd_l[9:2]), 64'h10);
    chk("tie_cap", 64'(rd_l[1:0]), 64'd0);
    // Full subtree: LEQ is dropped with an error.
    send(LEQ, 1'b0, 8'd1, 8'h01);
    chk("full_key", 64'(rd_l[17:10]), 64'd10);
    // Inactive node DEQ.
    send(DEQ, 1'b1, 8'd0, 8'h00);

    // Refill from the better child, then the lone child, then empty.
    do_reset();
    ch_act[0] = 1'b1; ch_key[0] = 8'd7; ch_data[0] = 8'h70; ch_cap[0] = 1'b0;
    ch_act[1] = 1'b1; ch_key[1] = 8'd3; ch_data[1] = 8'h30; ch_cap[1] = 1'b0;
    send(LEQ, 1'b0, 8'd5, 8'h55);
    send(DEQ, 1'b0, 8'd0, 8'h00);
    chk("deq_key", 64'(rd_l[17:10]), 64'd3);
    chk("deq_cap", 64'(rd_l[1:0]), 64'd3);
    send(DEQ, 1'b0, 8'd0, 8'h00);
    send(DEQ, 1'b0, 8'd0, 8'h00);
    send(DEQ, 1'b0, 8'd0, 8'h00);

    // Stall: dn_* held, parent blocked, then reset discards the pending op.
    do_reset();
    send(LEQ, 1'b1, 8'd30, 8'h30);
    dn_ready = 1'b0;
    send(LEQ, 1'b1, 8'd40, 8'h40);
    for (int i = 0; i < 4; i++) begin
      chk("stall_dn_valid", 64'(dn_valid), 64'd1);
      chk("stall_up_ready", 64'(up_ready), 64'd0);
      if (sb_q.size() > 0)
        chk("stall_dn_hold", pack(dn_op, dn_idx, dn_key, dn_data), sb_q[0]);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("stall_rst_dn_valid", 64'(dn_valid), 64'd0);
    dn_ready = 1'b1;
    do_reset();
    send(LEQ, 1'b1, 8'd9, 8'h99);
    send(LEQ, 1'b1, 8'd4, 8'h44);
    repeat (3) tick();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
